// File: rtl/hazard_fwd_unit_if.sv
// Bus between the ID-stage controller and hazard_fwd_unit.
// master: controller/datapath side; slave: the hazard/forwarding unit.
interface hazard_fwd_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs_i;
    logic [REG_ADDR_W-1:0] id_rt_i;
    logic                  id_use_rs_i;
    logic                  id_use_rt_i;
    logic                  id_regwr_i;
    logic                  id_memrd_i;
    logic [REG_ADDR_W-1:0] id_dst_i;
    logic                  ex_br_taken_i;
    logic                  stall_o;
    logic                  flush_o;
    logic [1:0]            fwd_a_o;
    logic [1:0]            fwd_b_o;
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_regwr_i, id_memrd_i, id_dst_i, ex_br_taken_i,
        input  stall_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_regwr_i, id_memrd_i, id_dst_i, ex_br_taken_i,
        output stall_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard / forwarding controller for a 5-stage MIPS pipeline.
// Tracks destination tags of the instructions in EX/MEM/WB, raises a one-cycle load-use
// stall, passes branch flushes through, and registers operand forwarding selects.
// Optional feature macro WB_BYPASS_EN: when defined, a WB-slot match selects 2'b11 (WB
// latch); otherwise it selects 2'b00 and the regfile must be write-through.
module hazard_fwd_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    hazard_fwd_unit_if.slave   bus
);

    // Shadow slots. Only EX needs memrd: a load in MEM is resolved by forwarding.
    logic                  r_ex_vld, r_ex_regwr, r_ex_memrd;
    logic [REG_ADDR_W-1:0] r_ex_dst;
    logic                  r_mem_vld, r_mem_regwr;
    logic [REG_ADDR_W-1:0] r_mem_dst;
    logic                  r_wb_vld, r_wb_regwr;
    logic [REG_ADDR_W-1:0] r_wb_dst;

    logic [1:0]            r_fwd_a, r_fwd_b;
    logic [CNT_W-1:0]      r_stall_cnt, r_flush_cnt;

    logic                  w_a_ex, w_a_mem, w_a_wb;
    logic                  w_b_ex, w_b_mem, w_b_wb;
    logic                  w_stall, w_flush, w_bubble;
    logic [1:0]            w_sel_a, w_sel_b;

    function automatic logic f_match(input logic                  use_src,
                                     input logic [REG_ADDR_W-1:0] idx,
                                     input logic                  vld,
                                     input logic                  regwr,
                                     input logic [REG_ADDR_W-1:0] dst);
        return use_src && (idx != '0) && vld && regwr && (dst == idx);
    endfunction

    // Youngest producer wins.
    function automatic logic [1:0] f_sel(input logic m_ex, input logic m_mem, input logic m_wb);
        if (m_ex) begin
            return 2'b01;
        end else if (m_mem) begin
            return 2'b10;
        end else if (m_wb) begin
`ifdef WB_BYPASS_EN
            return 2'b11;
`else
            return 2'b00;
`endif
        end
        return 2'b00;
    endfunction

    // Source-vs-slot matches, hazard decisions and forwarding selects
    always_comb begin
        w_a_ex   = f_match(bus.id_use_rs_i, bus.id_rs_i, r_ex_vld, r_ex_regwr, r_ex_dst);
        w_a_mem  = f_match(bus.id_use_rs_i, bus.id_rs_i, r_mem_vld, r_mem_regwr, r_mem_dst);
        w_a_wb   = f_match(bus.id_use_rs_i, bus.id_rs_i, r_wb_vld, r_wb_regwr, r_wb_dst);
        w_b_ex   = f_match(bus.id_use_rt_i, bus.id_rt_i, r_ex_vld, r_ex_regwr, r_ex_dst);
        w_b_mem  = f_match(bus.id_use_rt_i, bus.id_rt_i, r_mem_vld, r_mem_regwr, r_mem_dst);
        w_b_wb   = f_match(bus.id_use_rt_i, bus.id_rt_i, r_wb_vld, r_wb_regwr, r_wb_dst);
        // Outputs are forced low during reset; flush suppresses stall.
        w_flush  = ~rst & bus.ex_br_taken_i;
        w_stall  = ~rst & ~bus.ex_br_taken_i & bus.id_valid_i & r_ex_memrd & (w_a_ex | w_b_ex);
        w_bubble = w_stall | w_flush;
        w_sel_a  = f_sel(w_a_ex, w_a_mem, w_a_wb);
        w_sel_b  = f_sel(w_b_ex, w_b_mem, w_b_wb);
    end

    // Shadow pipeline advance, registered forward selects and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_vld    <= 1'b0;
            r_ex_regwr  <= 1'b0;
            r_ex_memrd  <= 1'b0;
            r_ex_dst    <= '0;
            r_mem_vld   <= 1'b0;
            r_mem_regwr <= 1'b0;
            r_mem_dst   <= '0;
            r_wb_vld    <= 1'b0;
            r_wb_regwr  <= 1'b0;
            r_wb_dst    <= '0;
            r_fwd_a     <= 2'b00;
            r_fwd_b     <= 2'b00;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_ex_vld    <= bus.id_valid_i & ~w_bubble;
            r_ex_regwr  <= bus.id_regwr_i;
            r_ex_memrd  <= bus.id_memrd_i;
            r_ex_dst    <= bus.id_dst_i;
            r_mem_vld   <= r_ex_vld;
            r_mem_regwr <= r_ex_regwr;
            r_mem_dst   <= r_ex_dst;
            r_wb_vld    <= r_mem_vld;
            r_wb_regwr  <= r_mem_regwr;
            r_wb_dst    <= r_mem_dst;
            r_fwd_a     <= w_bubble ? 2'b00 : w_sel_a;
            r_fwd_b     <= w_bubble ? 2'b00 : w_sel_b;
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall_o     = w_stall;
    assign bus.flush_o     = w_flush;
    assign bus.fwd_a_o     = r_fwd_a;
    assign bus.fwd_b_o     = r_fwd_b;
    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;

endmodule
